// File: rtl/l2_mem_line_bridge.sv
// Serialises L2 line refills/writebacks into word accesses on a single-port BRAM,
// pipelined against a configurable read latency, with base rebasing and window masking.
module l2_mem_line_bridge #(
  parameter int          LINE_BITS   = 512,
  parameter int          WORD_BITS   = 32,
  parameter int          TNUM        = 22,
  parameter int          INUM        = 4,
  parameter logic [31:0] MEM_DEPTH   = 32'h0100_0000,
  parameter int          MEM_AW      = 24,
  parameter int          MEM_LATENCY = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0001_0094
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 req_valid,
  input  logic                 req_write,
  input  logic [TNUM-1:0]      req_tag,
  input  logic [TNUM-1:0]      write_tag,
  input  logic [INUM-1:0]      req_index,
  input  logic [LINE_BITS-1:0] write_data,
  output logic                 ready,
  output logic [LINE_BITS-1:0] read_data,
  output logic                 error,
  output logic                 busy,
  output logic                 mem_en,
  output logic                 mem_we,
  output logic [MEM_AW-1:0]    mem_addr,
  output logic [WORD_BITS-1:0] mem_wdata,
  input  logic [WORD_BITS-1:0] mem_rdata
);

  localparam int W   = LINE_BITS / WORD_BITS;
  localparam int LB  = $clog2(LINE_BITS / 8);
  localparam int WB  = $clog2(WORD_BITS / 8);
  localparam int KW  = (W > 1) ? $clog2(W) : 1;
  localparam int LAW = TNUM + INUM + LB;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                      state;
  logic [KW-1:0]                   k;
  logic                            wr_q;
  logic [LAW-1:0]                  la_q;
  logic                            any_in;
  logic [W-1:0][WORD_BITS-1:0]     line_q;
  logic [W-1:0][WORD_BITS-1:0]     rd_q;

  logic [MEM_LATENCY-1:0]          dl_valid;
  logic [MEM_LATENCY-1:0]          dl_win;
  logic [MEM_LATENCY-1:0][KW-1:0]  dl_slot;

  logic [32:0] byte_addr;
  logic [32:0] waddr;
  logic [32:0] word_idx;
  logic        borrow;
  logic        in_win;
  logic        issuing;
  logic        last_k;
  logic        cap;
  logic        cap_win;
  logic [KW-1:0] cap_slot;

  // NOTE: combinational logic uses blocking '=' so each line sees the value computed
  // just above it; sequential state below uses '<=' so all registers update together.
  always_comb begin
    byte_addr = 33'(la_q) + (33'(k) << WB);
    borrow    = byte_addr < {1'b0, BASE_ADDR};
    waddr     = byte_addr - {1'b0, BASE_ADDR};
    word_idx  = waddr >> WB;
    in_win    = !borrow && (word_idx < {1'b0, MEM_DEPTH});
  end

  assign issuing  = (state == S_ISSUE);
  assign last_k   = (k == KW'(W - 1));
  assign cap      = dl_valid[MEM_LATENCY-1];
  assign cap_win  = dl_win[MEM_LATENCY-1];
  assign cap_slot = dl_slot[MEM_LATENCY-1];

  // Reset is synchronous, so the strobes are also gated by rstn to stop a burst
  // in the very cycle reset is asserted rather than one edge later.
  assign mem_en    = rstn && issuing && in_win;
  assign mem_we    = mem_en && wr_q;
  assign mem_addr  = mem_en ? word_idx[MEM_AW-1:0] : '0;
  assign mem_wdata = mem_we ? line_q[k] : '0;
  assign ready     = rstn && (state == S_DONE);
  assign error     = ready && !any_in;
  assign busy      = rstn && (state != S_IDLE);
  assign read_data = rd_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state  <= S_IDLE;
      k      <= '0;
      wr_q   <= 1'b0;
      la_q   <= '0;
      any_in <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            wr_q   <= req_write;
            la_q   <= {(req_write ? write_tag : req_tag), req_index, {LB{1'b0}}};
            k      <= '0;
            any_in <= 1'b0;
            state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (in_win) any_in <= 1'b1;
          if (last_k) state <= wr_q ? S_DONE : S_DRAIN;
          else        k     <= k + 1'b1;
        end
        S_DRAIN: begin
          if (cap && cap_slot == KW'(W - 1)) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NOTE: the writeback line is pure datapath, fully reloaded on every accept, so it
  // carries no reset; read_data does reset because its value is visible after reset.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && req_valid) line_q <= write_data;
  end

  // Every issue slot of a read, masked or not, travels the delay line so the
  // completion time does not depend on how much of the line was in window.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dl_valid <= '0;
      dl_win   <= '0;
      dl_slot  <= '0;
    end else begin
      dl_valid[0] <= issuing && !wr_q;
      dl_win[0]   <= in_win;
      dl_slot[0]  <= k;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        dl_valid[i] <= dl_valid[i-1];
        dl_win[i]   <= dl_win[i-1];
        dl_slot[i]  <= dl_slot[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rd_q <= '0;
    end else if (cap) begin
      rd_q[cap_slot] <= cap_win ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_l2_mem_line_bridge.sv
// Scoreboard bench for l2_mem_line_bridge: a line-level reference model predicts
// every memory access and completion; monitors compare them as the DUT presents them.
module tb_l2_mem_line_bridge;

  localparam int      W      = 16;
  localparam int      L0     = 2;
  localparam int      L1     = 1;
  localparam longint  BASE   = 64'h1_0094;
  localparam longint  DEPTH  = 64'h100_0000;

  typedef struct { int cyc; logic err; logic [511:0] data; } rdy_t;
  typedef struct { int cyc; logic we; logic [23:0] addr; logic [31:0] wdata; } acc_t;

  logic         clk = 1'b0;
  logic         rstn;
  logic         req_valid, req_valid1, req_write;
  logic [21:0]  req_tag, write_tag;
  logic [3:0]   req_index;
  logic [511:0] write_data;

  logic         ready, error, busy, mem_en, mem_we;
  logic [511:0] read_data;
  logic [23:0]  mem_addr;
  logic [31:0]  mem_wdata, mem_rdata;

  logic         ready1, error1, busy1, mem_en1, mem_we1;
  logic [511:0] read_data1;
  logic [23:0]  mem_addr1;
  logic [31:0]  mem_wdata1, mem_rdata1;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0]  bram    [logic [23:0]];
  logic [31:0]  ref_mem [logic [23:0]];
  logic [31:0]  p0      [L0];
  logic [511:0] last_rd [2];
  rdy_t         q_rdy0[$];
  rdy_t         q_rdy1[$];
  acc_t         q_acc[$];

  l2_mem_line_bridge u0 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid), .req_write(req_write),
    .req_tag(req_tag), .write_tag(write_tag), .req_index(req_index),
    .write_data(write_data), .ready(ready), .read_data(read_data), .error(error),
    .busy(busy), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  l2_mem_line_bridge #(.MEM_LATENCY(L1)) u1 (
    .clk(clk), .rstn(rstn), .req_valid(req_valid1), .req_write(req_write),
    .req_tag(req_tag), .write_tag(write_tag), .req_index(req_index),
    .write_data(write_data), .ready(ready1), .read_data(read_data1), .error(error1),
    .busy(busy1), .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] bram_rd(input logic [23:0] a);
    return bram.exists(a) ? bram[a] : 32'hA000_0000 + {8'h0, a};
  endfunction

  function automatic logic [31:0] ref_rd(input logic [23:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : 32'hA000_0000 + {8'h0, a};
  endfunction

  // BRAM models; idle read ports return a marker so unmasked garbage is visible.
  always @(posedge clk) begin
    if (mem_en && mem_we) bram[mem_addr] = mem_wdata;
    p0[0] <= (mem_en && !mem_we) ? bram_rd(mem_addr) : 32'hDEAD_BEEF;
    for (int i = 1; i < L0; i++) p0[i] <= p0[i-1];
  end
  assign mem_rdata = p0[L0-1];

  always @(posedge clk) begin
    if (mem_en1 && mem_we1) bram[mem_addr1] = mem_wdata1;
    mem_rdata1 <= (mem_en1 && !mem_we1) ? bram_rd(mem_addr1) : 32'hDEAD_BEEF;
  end

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Line-level reference: walks the words of the line with plain byte arithmetic.
  task automatic model(input int unit, input logic wr, input logic [31:0] la,
                       input logic [511:0] wl, input int acc, input int nbeats,
                       input bit expect_ready);
    rdy_t         r;
    acc_t         a;
    logic [511:0] line;
    bit           any;
    longint       b;
    logic [23:0]  word;
    line = '0;
    any  = 0;
    for (int k = 0; k < W; k++) begin
      b = longint'(la) + 4 * k;
      if (b >= BASE && ((b - BASE) >> 2) < DEPTH) begin
        any  = 1;
        word = 24'((b - BASE) >> 2);
        if (k < nbeats) begin
          if (unit == 0) begin
            a.cyc = acc + k; a.we = wr; a.addr = word;
            a.wdata = wr ? wl[k*32 +: 32] : 32'h0;
            q_acc.push_back(a);
          end
          if (wr) ref_mem[word] = wl[k*32 +: 32];
        end
        if (!wr) line[k*32 +: 32] = ref_rd(word);
      end
    end
    if (!wr) last_rd[unit] = line;
    if (expect_ready) begin
      r.cyc  = acc + W + (wr ? 0 : (unit == 0 ? L0 : L1));
      r.err  = !any;
      r.data = last_rd[unit];
      if (unit == 0) q_rdy0.push_back(r);
      else           q_rdy1.push_back(r);
    end
  endtask

  // Issue one request (called #1 after a posedge with the DUT idle) and hold it until ready.
  task automatic do_txn(input int unit, input logic wr, input logic [31:0] la,
                        input logic [511:0] wl, input bit flip);
    logic [25:0] ln;
    int          n;
    ln         = la[31:6];
    req_write  = wr;
    req_index  = ln[3:0];
    req_tag    = wr ? 22'($urandom) : ln[25:4];
    write_tag  = wr ? ln[25:4] : 22'($urandom);
    write_data = wl;
    if (unit == 0) req_valid = 1'b1; else req_valid1 = 1'b1;
    model(unit, wr, la, wl, cyc + 1, W, 1);
    @(posedge clk); #1;
    if (flip) begin
      req_write  = ~wr;
      req_tag    = 22'($urandom);
      write_tag  = 22'($urandom);
      write_data = {16{$urandom}};
    end
    n = 0;
    while (1) begin
      @(negedge clk);
      if ((unit == 0) ? ready : ready1) break;
      n++;
      if (n > 100) break;
    end
    checks++;
    if (n > 100) begin
      failures++;
      $display("FAIL ready_timeout unit%0d la=%0h: got no ready expected ready within 100 cycles", unit, la);
    end
    @(posedge clk); #1;
    if (unit == 0) req_valid = 1'b0; else req_valid1 = 1'b0;
  endtask

  // Completion monitors.
  always @(negedge clk) begin
    rdy_t e;
    if (ready) begin
      if (q_rdy0.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready0: got ready at cycle %0d expected none", cyc);
      end else begin
        e = q_rdy0.pop_front();
        check("ready0_cycle", 512'(cyc), 512'(e.cyc));
        check("ready0_error", 512'(error), 512'(e.err));
        check("ready0_data", read_data, e.data);
      end
    end
    if (ready1) begin
      if (q_rdy1.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_ready1: got ready at cycle %0d expected none", cyc);
      end else begin
        e = q_rdy1.pop_front();
        check("ready1_cycle", 512'(cyc), 512'(e.cyc));
        check("ready1_error", 512'(error1), 512'(e.err));
        check("ready1_data", read_data1, e.data);
      end
    end
  end

  // Memory access monitor for the main instance.
  always @(negedge clk) begin
    acc_t e;
    if (mem_en) begin
      if (q_acc.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_mem_en: got access addr=%0h we=%0b at cycle %0d expected none",
                 mem_addr, mem_we, cyc);
      end else begin
        e = q_acc.pop_front();
        check("acc_cycle", 512'(cyc), 512'(e.cyc));
        check("acc_we", 512'(mem_we), 512'(e.we));
        check("acc_addr", 512'(mem_addr), 512'(e.addr));
        if (e.we) check("acc_wdata", 512'(mem_wdata), 512'(e.wdata));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test expected finish within 30000 cycles");
    $fatal(1);
  end

  initial begin
    logic [511:0] wl;
    logic [31:0]  la;
    logic [25:0]  ln;
    int           acc;

    last_rd[0] = '0;
    last_rd[1] = '0;
    rstn       = 1'b0;
    req_valid  = 1'b1;
    req_valid1 = 1'b1;
    req_write  = 1'b1;
    req_tag    = 22'($urandom);
    write_tag  = 22'($urandom);
    req_index  = 4'($urandom);
    write_data = {16{$urandom}};

    // Reset holds everything at zero even with a request pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", 512'(ready), 512'(0));
    check("rst_error", 512'(error), 512'(0));
    check("rst_busy", 512'(busy), 512'(0));
    check("rst_mem_en", 512'(mem_en), 512'(0));
    check("rst_mem_we", 512'(mem_we), 512'(0));
    check("rst_mem_addr", 512'(mem_addr), 512'(0));
    check("rst_mem_wdata", 512'(mem_wdata), 512'(0));
    check("rst_read_data", read_data, 512'(0));
    check("rst_busy1", 512'(busy1), 512'(0));
    @(posedge clk); #1;
    req_valid  = 1'b0;
    req_valid1 = 1'b0;
    rstn       = 1'b1;
    @(posedge clk); #1;

    do_txn(0, 1'b0, 32'h100C0, '0, 0);     // aligned read, words 0x0B..0x1A
    do_txn(1, 1'b0, 32'h100C0, '0, 0);     // same with one-cycle memory latency
    do_txn(0, 1'b0, 32'h10080, '0, 0);     // straddles BASE_ADDR
    for (int k = 0; k < W; k++) wl[k*32 +: 32] = 32'h5500_0000 + k;
    do_txn(0, 1'b1, 32'h20000, wl, 0);
    do_txn(0, 1'b0, 32'h20000, '0, 0);
    do_txn(0, 1'b0, 32'h00000, '0, 0);     // entirely below the window
    do_txn(0, 1'b0, 32'h4010080, '0, 0);   // straddles the memory top
    for (int k = 0; k < W; k++) wl[k*32 +: 32] = $urandom;
    do_txn(0, 1'b1, 32'h4010080, wl, 1);
    do_txn(0, 1'b0, 32'h4010080, '0, 0);

    // Reset after the fifth write beat: only five words land, no completion.
    for (int k = 0; k < W; k++) wl[k*32 +: 32] = $urandom;
    la         = 32'h30000;
    req_write  = 1'b1;
    write_tag  = la[31:10];
    req_tag    = 22'($urandom);
    req_index  = la[9:6];
    write_data = wl;
    req_valid  = 1'b1;
    acc        = cyc + 1;
    model(0, 1'b1, la, wl, acc, 5, 0);
    @(posedge clk); #1;
    repeat (5) @(posedge clk);
    #1;
    rstn      = 1'b0;
    req_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rstn       = 1'b1;
    last_rd[0] = '0;
    last_rd[1] = '0;
    check("abort_pending_accesses", 512'(q_acc.size()), 512'(0));
    q_acc.delete();
    do_txn(0, 1'b0, 32'h30000, '0, 0);
    do_txn(0, 1'b0, 32'h100C0, '0, 0);

    // Randomised traffic around the window edges and written regions.
    for (int t = 0; t < 24; t++) begin
      case ($urandom_range(0, 3))
        0:       ln = 26'(32'h400 + $urandom_range(0, 10));
        1:       ln = 26'(32'h100401 + $urandom_range(0, 2));
        2:       ln = 26'($urandom);
        default: ln = 26'(32'h800 + $urandom_range(0, 3));
      endcase
      for (int k = 0; k < W; k++) wl[k*32 +: 32] = $urandom;
      do_txn(0, 1'($urandom), {ln, 6'b0}, wl, 1'($urandom));
    end
    do_txn(1, 1'b0, 32'h20000, '0, 1);

    repeat (5) @(posedge clk);
    check("left_ready0", 512'(q_rdy0.size()), 512'(0));
    check("left_ready1", 512'(q_rdy1.size()), 512'(0));
    check("left_accesses", 512'(q_acc.size()), 512'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
